// File: rtl/comprobador_compuertas.sv
// Stimulus driver and checker for a two-input logic-gate block.
// On inicio it sweeps {entrada1,entrada2} through 00,01,10,11, lets each
// combination settle, compares the eight gate outputs against the expected
// truth table, and reports a saturating error count, a sticky per-output
// failure mask and a pass/fail flag.
module comprobador_compuertas #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  output logic             entrada1,
  output logic             entrada2,
  input  logic             salidaand,
  input  logic             salidaor,
  input  logic             salidaxor,
  input  logic             salidanot,
  input  logic             salidanand,
  input  logic             salidayes,
  input  logic             salidanor,
  input  logic             salidaxnor,
  output logic             ocupado,
  output logic             hecho,
  output logic             aprobado,
  output logic [ERR_W-1:0] errores,
  output logic [7:0]       mascara
);

  typedef enum logic [2:0] {
    IDLE,
    APLICA,
    ESPERA,
    MUESTRA,
    FIN
  } estado_t;

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam int unsigned SUM_W = ((ERR_W > 4) ? ERR_W : 4) + 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  estado_t          estado;
  logic [1:0]       combo;
  logic [CNT_W-1:0] cnt;

  logic [7:0]       esperado;
  logic [7:0]       obtenido;
  logic [7:0]       diff;
  logic [3:0]       pop;
  logic [SUM_W-1:0] suma;
  logic [ERR_W-1:0] err_sig;

  // Expected vs observed gate outputs, mismatch popcount and saturating error sum
  always_comb begin
    esperado = {~(entrada1 ^ entrada2), ~(entrada1 | entrada2), entrada1,
                ~(entrada1 & entrada2), ~entrada1, entrada1 ^ entrada2,
                entrada1 | entrada2, entrada1 & entrada2};
    obtenido = {salidaxnor, salidanor, salidayes, salidanand,
                salidanot, salidaxor, salidaor, salidaand};
    diff = obtenido ^ esperado;
    pop  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pop = pop + 4'(diff[i]);
    end
    suma = SUM_W'(errores) + SUM_W'(pop);
    if (suma > SUM_W'(ERR_MAX)) begin
      err_sig = ERR_MAX;
    end else begin
      err_sig = ERR_W'(suma);
    end
  end

  // Sweep sequencer with registered stimulus and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= IDLE;
      combo    <= '0;
      cnt      <= '0;
      entrada1 <= 1'b0;
      entrada2 <= 1'b0;
      ocupado  <= 1'b0;
      hecho    <= 1'b0;
      aprobado <= 1'b0;
      errores  <= '0;
      mascara  <= '0;
    end else begin
      case (estado)
        IDLE, FIN: begin
          if (inicio) begin
            errores  <= '0;
            mascara  <= '0;
            hecho    <= 1'b0;
            aprobado <= 1'b0;
            combo    <= '0;
            ocupado  <= 1'b1;
            estado   <= APLICA;
          end
        end
        APLICA: begin
          entrada1 <= combo[1];
          entrada2 <= combo[0];
          cnt      <= '0;
          estado   <= ESPERA;
        end
        ESPERA: begin
          if (cnt == CNT_LAST) begin
            estado <= MUESTRA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUESTRA: begin
          mascara <= mascara | diff;
          errores <= err_sig;
          if (combo == 2'd3) begin
            estado   <= FIN;
            ocupado  <= 1'b0;
            hecho    <= 1'b1;
            aprobado <= (err_sig == '0);
          end else begin
            combo  <= combo + 1'b1;
            estado <= APLICA;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comprobador_compuertas.sv
// Bench for comprobador_compuertas: a behavioural gate block with per-combination
// fault masks and optional post-change glitches, plus a second checker instance
// with a narrow error counter driven by a fully inverted gate block.
module tb_comprobador_compuertas;

  logic clk = 1'b0;
  logic rst_n;
  logic inicio, inicio4;

  logic e1, e2, e41, e42;
  logic [7:0] g6, g4;
  logic ocupado, hecho, aprobado, ocupado4, hecho4, aprobado4;
  logic [5:0] errores;
  logic [3:0] errores4;
  logic [7:0] mascara, mascara4;

  logic [7:0] flt [4];
  bit         glitch_en;
  logic [1:0] prev6;
  logic [7:0] garbage;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comprobador_compuertas #(.SETTLE_CYCLES(2), .ERR_W(6)) u6 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio),
    .entrada1(e1), .entrada2(e2),
    .salidaand(g6[0]), .salidaor(g6[1]), .salidaxor(g6[2]), .salidanot(g6[3]),
    .salidanand(g6[4]), .salidayes(g6[5]), .salidanor(g6[6]), .salidaxnor(g6[7]),
    .ocupado(ocupado), .hecho(hecho), .aprobado(aprobado),
    .errores(errores), .mascara(mascara)
  );

  comprobador_compuertas #(.SETTLE_CYCLES(2), .ERR_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio4),
    .entrada1(e41), .entrada2(e42),
    .salidaand(g4[0]), .salidaor(g4[1]), .salidaxor(g4[2]), .salidanot(g4[3]),
    .salidanand(g4[4]), .salidayes(g4[5]), .salidanor(g4[6]), .salidaxnor(g4[7]),
    .ocupado(ocupado4), .hecho(hecho4), .aprobado(aprobado4),
    .errores(errores4), .mascara(mascara4)
  );

  // Truth table of a healthy gate block, bit order and,or,xor,not,nand,yes,nor,xnor
  function automatic logic [7:0] gates(input logic a, input logic b);
    logic [7:0] v;
    v[0] = a & b;  v[1] = a | b;     v[2] = a ^ b;     v[3] = ~a;
    v[4] = ~(a & b); v[5] = a;       v[6] = ~(a | b);  v[7] = ~(a ^ b);
    return v;
  endfunction

  // Glitch source: garbage for one clock after the stimulus changes
  always @(posedge clk) begin
    prev6   <= {e1, e2};
    garbage <= 8'($urandom);
  end

  always_comb begin
    if (glitch_en && ({e1, e2} != prev6)) g6 = garbage;
    else g6 = gates(e1, e2) ^ flt[{e1, e2}];
  end

  always_comb g4 = ~gates(e41, e42);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: total mismatching bits over the sweep, saturated; OR of all faults
  task automatic ref_eval(input int unsigned emax, output int unsigned e, output logic [7:0] m);
    int unsigned n = 0;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      n += $countones(flt[c]);
      m |= flt[c];
    end
    e = (n > emax) ? emax : n;
  endtask

  // One full sweep on the ERR_W=6 instance, checking stimulus order and results
  task automatic run_main(input string tag, input bit mid_pulse);
    int k;
    int unsigned ee;
    logic [7:0] em;
    ref_eval(63, ee, em);
    @(negedge clk); inicio = 1'b1;
    @(posedge clk); #1; inicio = 1'b0;
    chk({tag, "_busy0"}, ocupado, 1);
    k = 0;
    while (!hecho && k < 100) begin
      if (mid_pulse && k == 2) inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      k++;
      if (k <= 16) chk({tag, "_stim"}, {e1, e2}, (k - 1) / 4);
      if (!hecho) chk({tag, "_busy"}, ocupado, 1);
    end
    chk({tag, "_latency"}, k, 16);
    chk({tag, "_hecho"}, hecho, 1);
    chk({tag, "_ocupado"}, ocupado, 0);
    chk({tag, "_errores"}, errores, ee);
    chk({tag, "_mascara"}, mascara, em);
    chk({tag, "_aprobado"}, aprobado, (ee == 0));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_stim"}, {e1, e2}, 2'b11);
    chk({tag, "_hold_hecho"}, hecho, 1);
    chk({tag, "_hold_err"}, errores, ee);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; inicio = 1'b0; inicio4 = 1'b0; glitch_en = 1'b0;
    for (int c = 0; c < 4; c++) flt[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {e1, e2, ocupado, hecho, aprobado, errores, mascara}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outs", {e1, e2, ocupado, hecho, aprobado, errores, mascara}, '0);

    run_main("clean", 1'b0);

    flt[3] = 8'h01;
    run_main("and_sa0", 1'b0);
    chk("and_sa0_err_const", errores, 1);
    chk("and_sa0_mask_const", mascara, 8'h01);

    for (int c = 0; c < 4; c++) flt[c] = 8'h04;
    run_main("xor_inv", 1'b0);
    chk("xor_inv_err_const", errores, 4);

    flt[0] = 8'h00; flt[1] = 8'h00; flt[2] = 8'h08; flt[3] = 8'h08;
    run_main("not_sa1", 1'b0);
    chk("not_sa1_mask_const", mascara, 8'h08);

    for (int c = 0; c < 4; c++) flt[c] = '0;
    run_main("mid_inicio", 1'b1);

    glitch_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < 4; c++) flt[c] = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if (it == 0) for (int c = 0; c < 4; c++) flt[c] = '0;
      run_main("rand", 1'b0);
    end
    glitch_en = 1'b0;

    // Saturating counter on the narrow instance
    @(negedge clk); inicio4 = 1'b1;
    @(posedge clk); #1; inicio4 = 1'b0;
    k = 0;
    while (!hecho4 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("sat_latency", k, 16);
    chk("sat_errores", errores4, (32 > 15) ? 15 : 32);
    chk("sat_mascara", mascara4, 8'hFF);
    chk("sat_aprobado", aprobado4, 0);

    // Reset mid-sweep aborts immediately
    for (int c = 0; c < 4; c++) flt[c] = 8'h10;
    @(negedge clk); inicio = 1'b1;
    @(posedge clk); #1; inicio = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_busy", ocupado, 1);
    chk("pre_rst_stim", {e1, e2}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {e1, e2, ocupado, hecho, aprobado, errores, mascara}, '0);
    chk("async_rst4", {e41, e42, ocupado4, hecho4, aprobado4, errores4, mascara4}, '0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) flt[c] = '0;
    run_main("after_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
